// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the two-digit BCD countdown timer: state encoding,
// tick divider derivation, preset-to-BCD conversion and active-low 7-segment patterns.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    localparam logic [7:0] ANODE_OFF  = 8'hFF;
    localparam logic [7:0] ANODE_ONES = {ANODE_OFF[7:2], 2'b10};
    localparam logic [7:0] ANODE_TENS = {ANODE_OFF[7:2], 2'b01};
    localparam logic [5:0] PRESET_MAX = 6'd59;

    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Clamp to 59, then split into {tens, ones}.
    function automatic logic [7:0] preset_to_bcd(input logic [5:0] preset);
        logic [5:0] p;
        p = (preset > PRESET_MAX) ? PRESET_MAX : preset;
        return {4'(p / 6'd10), 4'(p % 6'd10)};
    endfunction

    // Active-low {dp,g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [7:0] seg7(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_tick_gen.sv
// Tick divider: counts 0..TICK_DIV-1 while enabled and pulses Tick on the terminal count.
// Clear restarts the count; the count holds while En is low.
module bcd_countdown_timer_tick_gen
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    input  logic En,
    output logic Tick
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign Tick = En && (cnt_q == CNT_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (Clear) begin
            cnt_q <= '0;
        end else if (En) begin
            cnt_q <= Tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (00..59) with Start/Pause control, Done level and a
// multiplexed active-low two-digit seven-segment display.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned TICK_HZ      = 1,
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Pause,
    input  logic [5:0] Preset,
    output logic       Running,
    output logic       Done,
    output logic [7:0] Anode,
    output logic [7:0] Display
);

    state_e                  state_q, state_d;
    logic [3:0]              tens_q, tens_d;
    logic [3:0]              ones_q, ones_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [3:0]              digit_q;
    logic [7:0]              anode_q;
    logic                    running_q;
    logic                    done_q;
    logic [7:0]              load_bcd;
    logic                    tick;

    assign load_bcd = preset_to_bcd(Preset);

    bcd_countdown_timer_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .Clk   (Clk),
        .Reset (Reset),
        .Clear (Start),
        .En    (state_q == StRun),
        .Tick  (tick)
    );

    // Start overrides everything; Pause overrides a coincident tick.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (Start) begin
            tens_d  = load_bcd[7:4];
            ones_d  = load_bcd[3:0];
            state_d = (load_bcd == 8'h00) ? StDone : StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (Pause) begin
                        state_d = StPause;
                    end else if (tick) begin
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            tens_d = tens_q - 4'd1;
                            ones_d = 4'd9;
                        end
                        if (tens_q == 4'd0 && ones_q == 4'd1) begin
                            state_d = StDone;
                        end
                    end
                end
                StPause: begin
                    if (Pause) begin
                        state_d = StRun;
                    end
                end
                default: ;
            endcase
        end
    end

    assign refresh_d = refresh_q + 1'b1;

    // Display registers follow the next refresh/digit values so Anode and digit stay aligned.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            refresh_q <= '0;
            digit_q   <= 4'd0;
            anode_q   <= ANODE_ONES;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            refresh_q <= refresh_d;
            digit_q   <= refresh_d[REFRESH_BITS-1] ? tens_d : ones_d;
            anode_q   <= refresh_d[REFRESH_BITS-1] ? ANODE_TENS : ANODE_ONES;
            running_q <= (state_d == StRun);
            done_q    <= (state_d == StDone);
        end
    end

    assign Running = running_q;
    assign Done    = done_q;
    assign Anode   = anode_q;
    assign Display = seg7(digit_q);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: the driver advances a seconds-level model and
// queues the expected outputs per clock; a monitor pops and compares after each edge.
module tb_bcd_countdown_timer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;
    localparam int DIV     = 10;
    localparam int REFRESH = 8;

    typedef struct packed {
        logic       running;
        logic       done;
        logic [7:0] anode;
        logic [7:0] display;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [5:0] preset = 6'd0;
    logic       running;
    logic       done;
    logic [7:0] anode;
    logic [7:0] display;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    obs_t exp_q [$];

    // Behavioural model: remaining seconds as a plain integer.
    int m_state = M_IDLE;
    int m_secs = 0;
    int m_phase = 0;
    int m_refresh = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(
        .CLK_HZ       (10),
        .TICK_HZ      (1),
        .REFRESH_BITS (3)
    ) dut (
        .Clk     (clk),
        .Reset   (rst),
        .Start   (start),
        .Pause   (pause),
        .Preset  (preset),
        .Running (running),
        .Done    (done),
        .Anode   (anode),
        .Display (display)
    );

    function automatic obs_t model_out();
        obs_t o;
        bit   hi;
        hi        = (m_refresh >= REFRESH / 2);
        o.running = (m_state == M_RUN);
        o.done    = (m_state == M_DONE);
        o.anode   = hi ? 8'hFD : 8'hFE;
        o.display = seg_tab[hi ? (m_secs / 10) : (m_secs % 10)];
        return o;
    endfunction

    function automatic obs_t dut_out();
        obs_t o;
        o.running = running;
        o.done    = done;
        o.anode   = anode;
        o.display = display;
        return o;
    endfunction

    task automatic model_step(input bit s, input bit p, input int pre);
        bit tick;
        int v;
        m_refresh = (m_refresh + 1) % REFRESH;
        tick = (m_state == M_RUN) && (m_phase == DIV - 1);
        if (s) m_phase = 0;
        else if (m_state == M_RUN) m_phase = (m_phase + 1) % DIV;
        if (s) begin
            v       = (pre > 59) ? 59 : pre;
            m_secs  = v;
            m_state = (v == 0) ? M_DONE : M_RUN;
        end else if (m_state == M_RUN) begin
            if (p) begin
                m_state = M_PAUSE;
            end else if (tick) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) m_state = M_DONE;
            end
        end else if (m_state == M_PAUSE && p) begin
            m_state = M_RUN;
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit p, input int pre);
        obs_t got;
        obs_t want;
        @(negedge clk);
        rst    = r;
        start  = s;
        pause  = p;
        preset = 6'(pre);
        if (r) begin
            m_state   = M_IDLE;
            m_secs    = 0;
            m_phase   = 0;
            m_refresh = 0;
            #1;
            got  = dut_out();
            want = model_out();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL async_reset t=%0t got run=%b done=%b an=%h seg=%h want run=%b done=%b an=%h seg=%h",
                         $time, got.running, got.done, got.anode, got.display,
                         want.running, want.done, want.anode, want.display);
            end
        end else begin
            model_step(s, p, pre);
        end
        exp_q.push_back(model_out());
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic load(input int pre);
        cycle(1'b0, 1'b1, 1'b0, pre);
    endtask

    // Monitor: one expected entry per clock edge once the driver is active.
    initial begin
        obs_t got;
        obs_t want;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t got nothing queued want one entry", $time);
                end else begin
                    want = exp_q.pop_front();
                    got  = dut_out();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL outputs t=%0t got run=%b done=%b an=%h seg=%h want run=%b done=%b an=%h seg=%h",
                                 $time, got.running, got.done, got.anode, got.display,
                                 want.running, want.done, want.anode, want.display);
                    end
                end
            end
        end
    end

    initial begin
        int pre;
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        idle(9);

        load(3);      idle(35);
        load(10);     idle(12);

        load(45);     idle(4);
        cycle(1'b0, 1'b0, 1'b1, 0);
        idle(50);
        cycle(1'b0, 1'b0, 1'b1, 0);
        idle(10);

        load(0);      idle(3);
        cycle(1'b0, 1'b0, 1'b1, 0);
        idle(2);
        load(63);     idle(12);

        load(20);     idle(3);
        cycle(1'b0, 1'b1, 1'b1, 20);
        idle(3);
        load(20);     idle(9);
        load(20);     idle(12);

        load(27);     idle(5);
        cycle(1'b1, 1'b0, 1'b0, 0);
        idle(12);

        for (int i = 0; i < 1500; i++) begin
            pre = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                              : int'($urandom_range(0, 5));
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 14) == 0), pre);
        end
        idle(2);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
